// File: rtl/temp_datapath.sv
// temp_datapath: three-stage compare datapath for the temperature controller.
//   S1 captures troom/tref/dt and forms the hysteresis band edges lo/hi,
//   S2 produces the raw decision flags, S3 updates datapath_out.
//   datapath_out = {cool_done, heat_done, need_cool, need_heat}.
// Build option: define TEMP_DP_FILTER_EN to enable the per-flag persistence
// filter; without it datapath_out is simply the raw flags registered at S3.
module temp_datapath #(
   parameter int W      = 7,
   parameter int FILT_N = 3,
   parameter int CNT_W  = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         sample_en,
   input  logic [W-1:0] datapath_in1,
   input  logic [W-1:0] datapath_in2,
   input  logic [W-1:0] datapath_in3,
   output logic [3:0]   datapath_out,
   output logic         out_valid
);

   // Two extra bits: one for the carry of tref+dt, one for the sign of tref-dt.
   localparam int SW = W + 2;

   // The filter counter has to be able to hold FILT_N-1.
   if (FILT_N < 1 || FILT_N > (1 << CNT_W)) begin : g_bad_cfg
      $error("temp_datapath: FILT_N must be >=1 and CNT_W must hold FILT_N-1");
   end

   logic [2:0]            vld_pipe;   // [0] S1 holds a sample, [1] S2, [2] out_valid
   logic [W-1:0]          s1_troom;
   logic [W-1:0]          s1_tref;
   logic signed [SW-1:0]  s1_lo;
   logic signed [SW-1:0]  s1_hi;
   logic [3:0]            s2_raw;
   logic signed [SW-1:0]  troom_s;
   logic signed [SW-1:0]  tref_s;

   assign out_valid = vld_pipe[2];
   assign troom_s   = $signed({2'b00, s1_troom});
   assign tref_s    = $signed({2'b00, s1_tref});

   // Valid shift register; reset drops every sample in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) vld_pipe <= '0;
      else       vld_pipe <= {vld_pipe[1:0], sample_en};
   end

   // S1: capture operands and form the band edges; the widened signed math never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_troom <= '0;
         s1_tref  <= '0;
         s1_lo    <= '0;
         s1_hi    <= '0;
      end else if (sample_en) begin
         s1_troom <= datapath_in1;
         s1_tref  <= datapath_in2;
         s1_lo    <= $signed({2'b00, datapath_in2}) - $signed({2'b00, datapath_in3});
         s1_hi    <= $signed({2'b00, datapath_in2}) + $signed({2'b00, datapath_in3});
      end
   end

   // S2: raw flags; lo<=hi always, so need_heat and need_cool cannot both be set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_raw <= '0;
      end else if (vld_pipe[0]) begin
         s2_raw[0] <= troom_s <  s1_lo;
         s2_raw[1] <= troom_s >  s1_hi;
         s2_raw[2] <= troom_s >= tref_s;
         s2_raw[3] <= troom_s <= tref_s;
      end
   end

`ifdef TEMP_DP_FILTER_EN
   logic [3:0][CNT_W-1:0] cnt;
   logic [3:0]            blocked;

   // A need_heat/need_cool rise waits while the opposite filtered flag is still set.
   assign blocked = {2'b00, s2_raw[1] & datapath_out[0], s2_raw[0] & datapath_out[1]};

   // S3: persistence filter. A flag changes only after FILT_N consecutive
   // disagreeing samples; a blocked rise keeps its counter parked at the
   // threshold so it takes effect on the next disagreeing sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         datapath_out <= '0;
         cnt          <= '0;
      end else if (vld_pipe[1]) begin
         for (int i = 0; i < 4; i++) begin
            if (s2_raw[i] == datapath_out[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_W'(FILT_N - 1)) begin
               if (!blocked[i]) begin
                  datapath_out[i] <= s2_raw[i];
                  cnt[i]          <= '0;
               end
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end
`else
   // S3: unfiltered, the raw flags go straight to the output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)            datapath_out <= '0;
      else if (vld_pipe[1]) datapath_out <= s2_raw;
   end
`endif

endmodule

// File: tb/tb_temp_datapath.sv
// tb_temp_datapath: randomized + directed bench for temp_datapath with a
// behavioural model (integer band math, pending-sample queue, streak counts).
module tb_temp_datapath;
   localparam int W      = 7;
   localparam int FILT_N = 3;
   localparam int CNT_W  = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         sample_en = 1'b0;
   logic [W-1:0] in1 = '0, in2 = '0, in3 = '0;
   logic [3:0]   dout;
   logic         ovld;

   always #5 clk = ~clk;

   temp_datapath #(.W(W), .FILT_N(FILT_N), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .sample_en(sample_en),
      .datapath_in1(in1), .datapath_in2(in2), .datapath_in3(in3),
      .datapath_out(dout), .out_valid(ovld)
   );

   typedef struct { int due; logic [3:0] raw; } pend_t;
   pend_t      pq[$];
   int         cyc = 0;
   logic [3:0] m_out = '0;
   logic       m_vld = 1'b0;
   int         streak[4] = '{default: 0};
   int         checks = 0, errors = 0;

   function automatic logic [3:0] raw_flags(int troom, int tref, int dt);
      logic [3:0] r;
      r[0] = troom < (tref - dt);
      r[1] = troom > (tref + dt);
      r[2] = troom >= tref;
      r[3] = troom <= tref;
      return r;
   endfunction

   task automatic apply_filter(input logic [3:0] raw);
`ifdef TEMP_DP_FILTER_EN
      logic [3:0] prev;
      logic       guard;
      prev = m_out;
      for (int i = 0; i < 4; i++) begin
         if (raw[i] == prev[i]) streak[i] = 0;
         else begin
            streak[i]++;
            guard = raw[i] && ((i == 0 && prev[1]) || (i == 1 && prev[0]));
            if (streak[i] >= FILT_N && !guard) begin
               m_out[i]  = raw[i];
               streak[i] = 0;
            end
         end
      end
`else
      m_out = raw;
`endif
   endtask

   task automatic model_edge(input logic en, input int a, input int b, input int c);
      pend_t p;
      cyc++;
      m_vld = 1'b0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
         p = pq.pop_front();
         apply_filter(p.raw);
         m_vld = 1'b1;
      end
      if (en) begin
         p.due = cyc + 2;
         p.raw = raw_flags(a, b, c);
         pq.push_back(p);
      end
   endtask

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive, edge, advance the model, compare.
   task automatic step(input logic en, input int a, input int b, input int c);
      sample_en = en;
      in1 = W'(a); in2 = W'(b); in3 = W'(c);
      @(posedge clk);
      model_edge(en, a, b, c);
      #1;
      check("out_valid", {3'b000, ovld}, {3'b000, m_vld});
      check("datapath_out", dout, m_out);
      check("need_excl", {3'b000, dout[0] & dout[1]}, 4'b0000);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0);
   endtask

   // n back-to-back samples of the same operands, then drain.
   task automatic burst(input int n, input int a, input int b, input int c);
      for (int i = 0; i < n; i++) step(1'b1, a, b, c);
      idle(2);
   endtask

   task automatic pin(input string name, input logic [3:0] lit);
      check({name, "_model"}, m_out, lit);
      check({name, "_dut"}, dout, lit);
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b1;
      sample_en = 1'b0;
      #1;
      check("reset_out", dout, 4'b0000);
      check("reset_valid", {3'b000, ovld}, 4'b0000);
      pq.delete();
      m_out = '0;
      m_vld = 1'b0;
      for (int i = 0; i < 4; i++) streak[i] = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   int n_rep;
   int tref, dt, tr;
   logic en;

   initial begin
`ifdef TEMP_DP_FILTER_EN
      n_rep = 4;
`else
      n_rep = 1;
`endif
      @(posedge clk);
      #1;
      check("por_out", dout, 4'b0000);
      check("por_valid", {3'b000, ovld}, 4'b0000);
      reset = 1'b0;
      idle(2);

      // Single sample: valid exactly two edges after the capture edge.
      step(1'b1, 15, 25, 3);
      step(1'b0, 0, 0, 0);
      check("lat_not_yet", {3'b000, ovld}, 4'b0000);
      step(1'b0, 0, 0, 0);
      check("lat_valid", {3'b000, ovld}, 4'b0001);
`ifdef TEMP_DP_FILTER_EN
      pin("filt_first", 4'b0000);
      burst(1, 15, 25, 3);
      pin("filt_second", 4'b0000);
      burst(1, 15, 25, 3);
      pin("filt_third", 4'b1001);
`else
      pin("cold", 4'b1001);
`endif

      // Band edges and equality.
      burst(n_rep, 40, 25, 3);  pin("hot", 4'b0110);
      burst(n_rep, 25, 25, 3);  pin("equal", 4'b1100);
      burst(n_rep, 22, 25, 3);  pin("at_lo", 4'b1000);
      burst(n_rep, 0, 2, 5);    pin("lo_neg", 4'b1000);
      burst(n_rep, 127, 125, 5); pin("hi_ovf", 4'b0100);
      burst(n_rep, 24, 25, 0);  pin("dt0", 4'b1001);
      burst(n_rep, 127, 125, 5); pin("hi_ovf2", 4'b0100);

      // need_heat pattern 1,1,0,1,1,1: the 0 clears the streak.
      burst(2, 10, 25, 3);
      burst(1, 23, 25, 3);
      burst(2, 10, 25, 3);
`ifdef TEMP_DP_FILTER_EN
      pin("pat_5th", 4'b1000);
`endif
      burst(1, 10, 25, 3);
      pin("pat_6th", 4'b1001);

      // Four back-to-back samples with different operands.
      step(1'b1, 30, 25, 2);
      step(1'b1, 20, 25, 2);
      step(1'b1, 25, 25, 0);
      step(1'b1, 100, 60, 50);
      idle(3);

      // Reset with samples in flight: they must never emerge.
      step(1'b1, 90, 20, 1);
      step(1'b1, 5, 90, 1);
      do_reset();
      idle(4);
      check("post_reset_out", dout, 4'b0000);
      step(1'b1, 50, 20, 4);
      idle(2);

      // Randomized stream with sticky operands so streaks and guards occur.
      tref = 60; dt = 4; tr = 60;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 15) == 0) tref = int'($urandom_range(0, 127));
         if ($urandom_range(0, 15) == 0) dt = int'($urandom_range(0, 10));
         if ($urandom_range(0, 3) == 0) begin
            tr = tref + int'($urandom_range(0, 40)) - 20;
            if (tr < 0) tr = 0;
            if (tr > 127) tr = 127;
         end
         en = ($urandom_range(0, 4) != 0);
         step(en, tr, tref, dt);
         if (n == 300) do_reset();
      end
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
